// File: rtl/bitcoin_pkg.sv
// Shared types and constants for the nonce result scanner: FSM states,
// result record layout and the record word selector.
package bitcoin_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } scan_state_t;

    localparam logic [1:0] REC_FOUND = 2'd0;
    localparam logic [1:0] REC_NONCE = 2'd1;
    localparam logic [1:0] REC_MIN   = 2'd2;

    localparam int DEF_NUM_NONCES = 16;

    // The nonce word reads all-ones when nothing beat the target, so the host
    // can test it without looking at the found word.
    function automatic logic [31:0] rec_word(input logic [1:0]  sel,
                                             input logic        found,
                                             input logic [31:0] win_ext,
                                             input logic [31:0] min_hash);
        logic [31:0] w;
        w = min_hash;
        case (sel)
            REC_FOUND: w = {31'b0, found};
            REC_NONCE: w = found ? win_ext : 32'hFFFF_FFFF;
            default:   w = min_hash;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/hash_compare_unit.sv
// Running comparison of returned hash words: first index below target and
// the minimum word seen so far.
module hash_compare_unit #(
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             valid,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      data,
    input  logic [31:0]      target,
    output logic             found,
    output logic [IDX_W-1:0] win_nonce,
    output logic [31:0]      min_hash
);

    logic hit;
    assign hit = data < target;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            found     <= 1'b0;
            win_nonce <= '1;
            min_hash  <= 32'hFFFF_FFFF;
        end else if (clear) begin
            found     <= 1'b0;
            win_nonce <= '1;
            min_hash  <= 32'hFFFF_FFFF;
        end else if (valid) begin
            // Words arrive in index order, so the first hit is the lowest nonce.
            if (hit && !found) begin
                found     <= 1'b1;
                win_nonce <= idx;
            end
            if (data < min_hash)
                min_hash <= data;
        end
    end

endmodule

// File: rtl/nonce_result_scan.sv
// Reads NUM_NONCES hash words back over the shared memory port, finds the
// winning nonce and minimum hash, then writes a 3-word result record.
module nonce_result_scan
    import bitcoin_pkg::*;
#(
    parameter int NUM_NONCES = DEF_NUM_NONCES,
    parameter int IDX_W      = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [15:0]      hash_addr,
    input  logic [15:0]      report_addr,
    input  logic [31:0]      target,
    output logic             done,
    output logic             found,
    output logic [IDX_W-1:0] win_nonce,
    output logic [31:0]      min_hash,
    output logic             mem_clk,
    output logic             mem_we,
    output logic [15:0]      mem_addr,
    output logic [31:0]      mem_write_data,
    input  logic [31:0]      mem_read_data
);

    scan_state_t      state;
    logic [31:0]      target_q;
    logic [15:0]      hash_q;
    logic [15:0]      report_q;
    logic [IDX_W-1:0] issue_cnt;
    logic [IDX_W-1:0] cmp_cnt;
    logic [1:0]       vld_pipe;
    logic [1:0]       wr_cnt;
    logic             issuing;
    logic             cmp_vld;
    logic             clear;

    assign mem_clk = clk;

    assign issuing = (state == SCAN) && (issue_cnt < IDX_W'(NUM_NONCES));
    // Memory returns data two edges after the address is registered, so each
    // issue is tracked through a two-stage valid shift register.
    assign cmp_vld = (state == SCAN) && vld_pipe[1];
    assign clear   = (state == IDLE) && start;

    hash_compare_unit #(.IDX_W(IDX_W)) u_cmp (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .valid     (cmp_vld),
        .idx       (cmp_cnt),
        .data      (mem_read_data),
        .target    (target_q),
        .found     (found),
        .win_nonce (win_nonce),
        .min_hash  (min_hash)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            target_q       <= '0;
            hash_q         <= '0;
            report_q       <= '0;
            issue_cnt      <= '0;
            cmp_cnt        <= '0;
            vld_pipe       <= '0;
            wr_cnt         <= '0;
            done           <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    mem_we   <= 1'b0;
                    vld_pipe <= '0;
                    if (start) begin
                        target_q  <= target;
                        hash_q    <= hash_addr;
                        report_q  <= report_addr;
                        mem_addr  <= hash_addr;
                        issue_cnt <= IDX_W'(1);
                        cmp_cnt   <= '0;
                        vld_pipe  <= 2'b01;
                        state     <= SCAN;
                    end
                end
                SCAN: begin
                    vld_pipe <= {vld_pipe[0], issuing};
                    if (issuing) begin
                        mem_addr  <= hash_q + 16'(issue_cnt);
                        issue_cnt <= issue_cnt + IDX_W'(1);
                    end
                    if (vld_pipe[1]) begin
                        cmp_cnt <= cmp_cnt + IDX_W'(1);
                        if (cmp_cnt == IDX_W'(NUM_NONCES - 1)) begin
                            wr_cnt <= REC_FOUND;
                            state  <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    mem_we         <= 1'b1;
                    mem_addr       <= report_q + 16'(wr_cnt);
                    mem_write_data <= rec_word(wr_cnt, found, 32'(win_nonce), min_hash);
                    wr_cnt         <= wr_cnt + 2'd1;
                    if (wr_cnt == REC_MIN)
                        state <= DONE;
                end
                DONE: begin
                    mem_we <= 1'b0;
                    done   <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nonce_result_scan.sv
// Scoreboard bench: expected record writes and done results are queued when a
// scan is started and checked by a monitor as the DUT presents them.
module tb_nonce_result_scan;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic        found;
        logic [7:0]  win;
        logic [31:0] min;
        int          se;
    } done_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] hash_addr = '0;
    logic [15:0] report_addr = '0;
    logic [31:0] target = '0;
    logic        done;
    logic        found;
    logic [7:0]  win_nonce;
    logic [31:0] min_hash;
    logic        mem_clk;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    logic        tb_we = 1'b0;
    logic [15:0] tb_addr = '0;
    logic [31:0] tb_data = '0;
    logic [31:0] mem [0:65535];
    logic [31:0] rd_q;

    int    cyc = 0;
    int    n_cmp = 0;
    int    n_err = 0;
    int    se;
    wr_t   wr_q[$];
    done_t done_q[$];
    wr_t   w_mon;
    done_t d_mon;

    nonce_result_scan #(.NUM_NONCES(16), .IDX_W(8)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .hash_addr      (hash_addr),
        .report_addr    (report_addr),
        .target         (target),
        .done           (done),
        .found          (found),
        .win_nonce      (win_nonce),
        .min_hash       (min_hash),
        .mem_clk        (mem_clk),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory: address registered at edge k is read at k+1 and sampled at k+2.
    always @(posedge clk) begin
        if (tb_we) mem[tb_addr] <= tb_data;
        else if (mem_we) mem[mem_addr] <= mem_write_data;
        rd_q <= mem[mem_addr];
    end
    assign mem_read_data = rd_q;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    always @(negedge clk) begin
        if (reset_n) begin
            if (mem_we) begin
                if (wr_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_addr, mem_write_data);
                end else begin
                    w_mon = wr_q.pop_front();
                    chk("wr_addr", {16'h0, mem_addr}, {16'h0, w_mon.addr});
                    chk("wr_data", mem_write_data, w_mon.data);
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_done: got done=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    d_mon = done_q.pop_front();
                    chk("found", {31'b0, found}, {31'b0, d_mon.found});
                    chk("win_nonce", {24'b0, win_nonce}, {24'b0, d_mon.win});
                    chk("min_hash", min_hash, d_mon.min);
                    chk("done_latency", cyc - d_mon.se, 21);
                end
            end
        end
    end

    task automatic load(input logic [15:0] a, input logic [31:0] d);
        @(negedge clk);
        tb_we = 1'b1; tb_addr = a; tb_data = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic start_scan(input logic [15:0] ha, input logic [15:0] ra,
                              input logic [31:0] tg, output int s);
        @(negedge clk);
        hash_addr = ha; report_addr = ra; target = tg; start = 1'b1;
        s = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic expect_run(input logic [15:0] r0a, input logic [15:0] r1a, input logic [15:0] r2a,
                              input logic [31:0] r0, input logic [31:0] r1, input logic [31:0] r2,
                              input logic f, input logic [7:0] w, input logic [31:0] m, input int s);
        wr_q.push_back('{addr: r0a, data: r0});
        wr_q.push_back('{addr: r1a, data: r1});
        wr_q.push_back('{addr: r2a, data: r2});
        done_q.push_back('{found: f, win: w, min: m, se: s});
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((wr_q.size() != 0 || done_q.size() != 0) && t < 200) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (t >= 200) begin
            n_err++;
            $display("FAIL drain_timeout: got %0d pending expected 0", wr_q.size() + done_q.size());
            wr_q.delete();
            done_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        chk("rst_done", {31'b0, done}, 32'h0);
        chk("rst_found", {31'b0, found}, 32'h0);
        chk("rst_win", {24'b0, win_nonce}, 32'hFF);
        chk("rst_min", min_hash, 32'hFFFF_FFFF);
        chk("rst_we", {31'b0, mem_we}, 32'h0);
        chk("rst_addr", {16'h0, mem_addr}, 32'h0);
        chk("rst_wdata", mem_write_data, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // T1: word i = i*0x1000_0000 + 5
        for (int i = 0; i < 16; i++) load(16'h0100 + 16'(i), 32'(i) * 32'h1000_0000 + 32'd5);
        start_scan(16'h0100, 16'h0200, 32'h3000_0000, se);
        expect_run(16'h0200, 16'h0201, 16'h0202, 32'h1, 32'h0, 32'h5, 1'b1, 8'h00, 32'h5, se);
        drain();
        chk("t1_mem0", mem[16'h0200], 32'h1);
        chk("t1_mem1", mem[16'h0201], 32'h0);
        chk("t1_mem2", mem[16'h0202], 32'h5);

        // T2: nothing beats the target
        for (int i = 0; i < 16; i++) load(16'h0300 + 16'(i), 32'hFFFF_FFF0);
        start_scan(16'h0300, 16'h0210, 32'h1000_0000, se);
        expect_run(16'h0210, 16'h0211, 16'h0212, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFF0,
                   1'b0, 8'hFF, 32'hFFFF_FFF0, se);
        drain();

        // T3: strict compare at equality, then back-to-back start while done is high
        for (int i = 0; i < 16; i++)
            load(16'h0600 + 16'(i), (i == 7 || i == 12) ? 32'h0000_00AA : 32'h8000_0000);
        start_scan(16'h0600, 16'h0220, 32'h0000_00AA, se);
        expect_run(16'h0220, 16'h0221, 16'h0222, 32'h0, 32'hFFFF_FFFF, 32'hAA,
                   1'b0, 8'hFF, 32'hAA, se);
        begin
            int t;
            t = 0;
            while (done !== 1'b1 && t < 100) begin
                @(negedge clk);
                t++;
            end
            chk("t3_done_seen", {31'b0, done}, 32'h1);
        end
        target = 32'h0000_00AB; start = 1'b1; report_addr = 16'h0230;
        se = cyc + 1;
        expect_run(16'h0230, 16'h0231, 16'h0232, 32'h1, 32'h7, 32'hAA, 1'b1, 8'h07, 32'hAA, se);
        @(negedge clk);
        start = 1'b0;
        drain();

        // T4: address wrap for both the hash block and the record
        for (int i = 0; i < 16; i++) load(16'hFFF8 + 16'(i), 32'h5000_0000 - 32'(i));
        start_scan(16'hFFF8, 16'hFFFF, 32'h4FFF_FFF5, se);
        expect_run(16'hFFFF, 16'h0000, 16'h0001, 32'h1, 32'hC, 32'h4FFF_FFF1,
                   1'b1, 8'h0C, 32'h4FFF_FFF1, se);
        drain();

        // T5: reset during the second record write
        for (int i = 0; i < 16; i++) load(16'h0700 + 16'(i), 32'(i) * 32'h1000_0000 + 32'd5);
        for (int i = 0; i < 3; i++) load(16'h0400 + 16'(i), 32'hDEAD_BEEF);
        start_scan(16'h0700, 16'h0400, 32'h3000_0000, se);
        wr_q.push_back('{addr: 16'h0400, data: 32'h1});
        while (cyc != se + 19) begin
            @(posedge clk);
            #1;
        end
        reset_n = 1'b0;
        #1;
        chk("mid_rst_we", {31'b0, mem_we}, 32'h0);
        chk("mid_rst_done", {31'b0, done}, 32'h0);
        chk("mid_rst_found", {31'b0, found}, 32'h0);
        chk("mid_rst_win", {24'b0, win_nonce}, 32'hFF);
        chk("mid_rst_min", min_hash, 32'hFFFF_FFFF);
        chk("mid_rst_addr", {16'h0, mem_addr}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("t5_pending", 32'(wr_q.size()), 32'h0);
        chk("t5_mem0", mem[16'h0400], 32'h1);
        chk("t5_mem1", mem[16'h0401], 32'hDEAD_BEEF);
        chk("t5_mem2", mem[16'h0402], 32'hDEAD_BEEF);
        start_scan(16'h0700, 16'h0400, 32'h3000_0000, se);
        expect_run(16'h0400, 16'h0401, 16'h0402, 32'h1, 32'h0, 32'h5, 1'b1, 8'h00, 32'h5, se);
        drain();
        chk("t5_rerun_mem1", mem[16'h0401], 32'h0);

        // T6: start pulses and input changes during the scan are ignored
        for (int i = 0; i < 16; i++) load(16'h0500 + 16'(i), 32'h2000_0000 + 32'(15 - i) * 32'h1000);
        start_scan(16'h0500, 16'h0240, 32'h2000_1000, se);
        expect_run(16'h0240, 16'h0241, 16'h0242, 32'h1, 32'hF, 32'h2000_0000,
                   1'b1, 8'h0F, 32'h2000_0000, se);
        repeat (2) @(negedge clk);
        start = 1'b1; target = 32'hFFFF_FFFF; hash_addr = 16'h0000; report_addr = 16'h0300;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (30) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/nonce_result_scan.md
Name: nonce_result_scan

Overview:
- Downstream stage of the multi-nonce hash engine.
- After the engine writes NUM_NONCES 32-bit hash words to memory, this block reads them back over the shared memory port. It compares each word against a difficulty target and finds the winning nonce and the minimum hash.
- It writes a 3-word result record to memory and pulses done.
- Sits between the hash engine's done and the host/control that polls the record.

Parameters:
- NUM_NONCES, 16, number of consecutive hash words to scan (index = nonce, 0..NUM_NONCES-1).
- IDX_W, 8, width of the reported nonce index; must satisfy 2**IDX_W > NUM_NONCES.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  begin scan; sampled only in IDLE
- hash_addr  input  16  base address of the NUM_NONCES hash words
- report_addr  input  16  base address of the 3-word result record
- target  input  32  unsigned difficulty target; captured at start
- done  output  1  one-cycle pulse when the record is written
- found  output  1  at least one hash < target (valid from done until next start)
- win_nonce  output  IDX_W  lowest index with hash < target; all-ones if none
- min_hash  output  32  smallest hash word scanned
- mem_clk  output  1  equals clk
- mem_we  output  1  memory write enable
- mem_addr  output  16  memory address
- mem_write_data  output  32  memory write data
- mem_read_data  input  32  memory read data

Behaviour:
- Reset values: done=0, found=0, win_nonce=all-ones, min_hash=32'hFFFFFFFF, mem_we=0, mem_addr=0, mem_write_data=0, state=IDLE.
- Memory timing: an address registered at edge k returns data that is sampled at edge k+2. Reads are pipelined, one address per cycle.
- IDLE:
  - On start, capture target, hash_addr and report_addr into internal registers.
  - Set mem_addr=hash_addr, issue counter=1, compare counter=0.
  - Clear found, set win_nonce=all-ones, set min_hash=FFFFFFFF.
  - Go to SCAN.
- SCAN:
  - Each edge, issue the next address (hash_addr+issue counter) until NUM_NONCES addresses have been issued.
  - Starting at the 2nd edge after start, each edge compares one returned word, in index order.
  - Compare rule is unsigned h < target (strict).
    - On the first hit, set found=1 and win_nonce=index; later hits do not change win_nonce.
  - Min rule is h < min_hash (strict), so ties keep the lower index.
  - After NUM_NONCES words have been compared, go to WRITE.
- WRITE, 3 consecutive edges, mem_we=1:
  - report_addr+0 <= {31'b0, found}
  - report_addr+1 <= win_nonce zero-extended to 32 bits (FFFFFFFF when none found)
  - report_addr+2 <= min_hash
  - Then go to DONE.
- DONE: mem_we=0, done=1 for exactly one cycle, return to IDLE.
- Latency: done is registered at edge NUM_NONCES+5 after the start edge; 21 for the default.
- start outside IDLE is ignored; inputs changing mid-scan have no effect because they are captured at start.
- Back-to-back operation: start may be asserted in the cycle done is high; it is accepted on the next IDLE edge.
- Address arithmetic is 16-bit modulo; base+index wraps past FFFF.
- Reset mid-operation returns to reset values immediately. No partial record write continues after reset; words already written remain in memory.
- mem_we is never asserted in IDLE or SCAN.

Decomposition:
- Shared package (bitcoin_pkg): state enum {IDLE, SCAN, WRITE, DONE}, record offset constants (REC_FOUND=0, REC_NONCE=1, REC_MIN=2), default NUM_NONCES.
- One sub-module: hash_compare_unit. It takes a valid pulse, index, data word and captured target, and keeps the running found/win_nonce/min_hash registers plus a clear input. The top keeps the FSM, counters and memory port.

Test Plan:
- Hash words i*0x1000_0000+5 (i=0..15), target=0x3000_0000 -> found=1, win_nonce=0, min_hash=0x0000_0005; record {1, 0, 5} at report_addr; done at edge 21.
- All words 0xFFFF_FFF0, target=0x1000_0000 -> found=0, win_nonce=0xFF, min_hash=0xFFFF_FFF0; record {0, 0xFFFF_FFFF, 0xFFFF_FFF0}.
- Word[7]=0x0000_00AA, word[12]=0x0000_00AA, all others 0x8000_0000, target=0x0000_00AA -> found=0 (strict compare), min_hash=0xAA; target=0x0000_00AB -> win_nonce=7.
- hash_addr=0xFFF8 -> read addresses 0xFFF8..0xFFFF then 0x0000..0x0007; report_addr=0xFFFF -> writes at 0xFFFF, 0x0000, 0x0001.
- Assert reset_n=0 on the 2nd WRITE cycle -> mem_we=0 and done=0 immediately, outputs at reset values, no further writes; a new start gives a full correct run.
- start pulses during SCAN and a target change mid-scan -> ignored; result matches the target captured at start, and exactly one done pulse per accepted start.
